// File: rtl/cvp_pwr_target.sv
// Responder end of the CVP "pwr" 4-phase req/ack interface: a synchronized request performs one
// 64-bit read or byte-masked write on a local register bank. Optional macro CVP_PWR_TGT_RO_ID_EN.
module cvp_pwr_target #(
    parameter int          NUM_REGS  = 16,
    parameter logic [63:0] RESET_VAL = 64'h0,
    parameter logic [63:0] ID_VAL    = 64'hC0DE_0001_0000_0000
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     pwr_req,
    input  logic                     pwr_wr_rd,
    input  logic [28:0]              pwr_add,
    input  logic [7:0]               pwr_be,
    input  logic [63:0]              pwr_data,
    output logic                     pwr_ack,
    output logic                     pwr_error,
    output logic [63:0]              pwr_r_data,
    output logic [NUM_REGS*64-1:0]   cfg_regs,
    output logic [NUM_REGS-1:0]      cfg_wr_pulse
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 req_s0_q, req_s_q;
    logic                 wr_rd_q, wr_rd_d;
    logic [28:0]          add_q, add_d;
    logic [7:0]           be_q, be_d;
    logic [63:0]          data_q, data_d;
    logic                 ack_q, ack_d;
    logic                 error_q, error_d;
    logic [63:0]          r_data_q, r_data_d;
    logic [NUM_REGS-1:0]  pulse_q, pulse_d;
    logic [63:0]          regs_q [NUM_REGS];
    logic [63:0]          regs_d [NUM_REGS];
    logic                 range_err, ro_err, err;
    logic [63:0]          rd_word;
    logic [NUM_REGS-1:0]  sel;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_w,
                                                input logic [63:0] new_w,
                                                input logic [7:0]  be);
        logic [63:0] res;
        res = old_w;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic [63:0] reg_reset_val(input int k);
`ifdef CVP_PWR_TGT_RO_ID_EN
        return (k == 0) ? ID_VAL : RESET_VAL;
`else
        return (k >= 0) ? RESET_VAL : RESET_VAL;
`endif
    endfunction

`ifndef CVP_PWR_TGT_RO_ID_EN
    logic unused_id;
    assign unused_id = ^ID_VAL;
`endif

    // Two-flop synchronizer; the FSM only ever looks at req_s_q.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            req_s0_q <= 1'b0;
            req_s_q  <= 1'b0;
        end else begin
            req_s0_q <= pwr_req;
            req_s_q  <= req_s0_q;
        end
    end

    // Full address width takes part in the range check, so stray high bits flag an error.
    always_comb begin
        range_err = (add_q >= 29'(NUM_REGS));
        ro_err    = 1'b0;
`ifdef CVP_PWR_TGT_RO_ID_EN
        ro_err    = (add_q == 29'd0) && !wr_rd_q && (be_q != 8'h00);
`endif
        err       = range_err | ro_err;
        sel       = '0;
        rd_word   = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (add_q == 29'(k)) begin
                sel[k]  = 1'b1;
                rd_word = regs_q[k];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_s_q) state_d = ACCESS;
            ACCESS:  state_d = ACK;
            ACK:     if (!req_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_rd_d  = wr_rd_q;
        add_d    = add_q;
        be_d     = be_q;
        data_d   = data_q;
        ack_d    = ack_q;
        error_d  = error_q;
        r_data_d = r_data_q;
        pulse_d  = '0;
        for (int k = 0; k < NUM_REGS; k++) regs_d[k] = regs_q[k];
        unique case (state_q)
            IDLE: begin
                if (req_s_q) begin
                    wr_rd_d = pwr_wr_rd;
                    add_d   = pwr_add;
                    be_d    = pwr_be;
                    data_d  = pwr_data;
                end
            end
            ACCESS: begin
                ack_d   = 1'b1;
                error_d = err;
                if (err) begin
                    r_data_d = '0;
                end else if (wr_rd_q) begin
                    r_data_d = rd_word;
                end else if (be_q != 8'h00) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (sel[k]) begin
                            regs_d[k]  = merge_bytes(regs_q[k], data_q, be_q);
                            pulse_d[k] = 1'b1;
                        end
                    end
                end
            end
            ACK: begin
                if (!req_s_q) ack_d = 1'b0;
            end
            default: ;
        endcase
`ifdef CVP_PWR_TGT_RO_ID_EN
        regs_d[0] = ID_VAL;
`endif
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_rd_q  <= 1'b0;
            add_q    <= '0;
            be_q     <= '0;
            data_q   <= '0;
            ack_q    <= 1'b0;
            error_q  <= 1'b0;
            r_data_q <= '0;
            pulse_q  <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= reg_reset_val(k);
        end else begin
            wr_rd_q  <= wr_rd_d;
            add_q    <= add_d;
            be_q     <= be_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            error_q  <= error_d;
            r_data_q <= r_data_d;
            pulse_q  <= pulse_d;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
        end
    end

    assign pwr_ack      = ack_q;
    assign pwr_error    = error_q;
    assign pwr_r_data   = r_data_q;
    assign cfg_wr_pulse = pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_regs[64*g +: 64] = regs_q[g];
    end

endmodule

// File: doc/cvp_pwr_target.md
Name: cvp_pwr_target

Overview:
- Responder (target) end of the CVP "pwr" 4-phase req/ack register-access interface.
- Receives requests from an asynchronous-domain initiator: two-flop-synchronizes pwr_req, performs one 64-bit read or byte-masked write on a local register bank, and returns data and error with a registered pwr_ack.
- Sits inside each CVP power/config domain; the register bank drives that domain's control fields.

Parameters:
- NUM_REGS, 16, number of 64-bit registers in the bank (1..256).
- RESET_VAL, 64'h0, reset value of every register (except register 0 when CVP_PWR_TGT_RO_ID_EN is defined).
- ID_VAL, 64'hC0DE_0001_0000_0000, read-only value of register 0 when CVP_PWR_TGT_RO_ID_EN is defined.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- pwr_req  in  1  request level from initiator (asynchronous; synchronized internally)
- pwr_wr_rd  in  1  1 = read, 0 = write
- pwr_add  in  29  64-bit word index
- pwr_be  in  8  byte enables (bit i covers data[8i+7:8i])
- pwr_data  in  64  write data
- pwr_ack  out  1  acknowledge level (registered)
- pwr_error  out  1  access error, valid while pwr_ack=1
- pwr_r_data  out  64  read data, valid while pwr_ack=1
- cfg_regs  out  NUM_REGS*64  flat register bank; register k is at [64k+63:64k]
- cfg_wr_pulse  out  NUM_REGS  one-cycle pulse when register k is updated

Behaviour:
- One clock, HCLK. Reset is asynchronous and active-low on HRESETn; all flops clear on it.
- Reset values: pwr_ack=0, pwr_error=0, pwr_r_data=0, cfg_wr_pulse=0, every register = RESET_VAL, state=IDLE, both sync flops = 0.
- Synchronizer: req_s0 <= pwr_req; req_s <= req_s0. The FSM uses only req_s.
- Request fields are stable for at least 2 HCLK cycles before req_s rises. They are captured into holding registers at the IDLE→ACCESS transition.
- FSM states are IDLE, ACCESS, ACK.
  - IDLE: if req_s=1, capture wr_rd/add/be/data and go to ACCESS; otherwise stay.
  - ACCESS: go to ACK unconditionally. This is a single cycle, in which:
    - err = (add >= NUM_REGS).
    - Write, no error: for each i with be[i]=1, reg[add] byte i <= data byte i. Assert cfg_wr_pulse[add] for this cycle only when be != 0.
    - Read, no error: pwr_r_data <= reg[add], full 64 bits; be is ignored.
    - Error: no register changes, no pulse, pwr_r_data <= 0.
    - pwr_error <= err.
    - pwr_ack <= 1 (the flop takes effect on entry to ACK).
  - ACK: hold pwr_ack=1. When req_s=0, clear pwr_ack to 0 and go to IDLE.
- Latency: pwr_req rise → pwr_ack rise = 4 HCLK edges (2 sync, IDLE capture, ACCESS). pwr_req fall → pwr_ack fall = 3 edges.
- pwr_r_data and pwr_error hold their values after ack falls, until the next ACCESS.
- A new request is not accepted until the FSM has returned to IDLE. req_s is already 0 on return, so there is no re-trigger.
- pwr_req glitch (rise and fall within 1 cycle, never reaching req_s): ignored.
- Reset asserted mid-transaction: ack drops immediately, a write is abandoned if ACCESS has not completed, and the register bank returns to reset values.
- Unused upper pwr_add bits take part in the range check. Any nonzero bit above the index range therefore sets the error.

Optional Feature:
- Macro: CVP_PWR_TGT_RO_ID_EN.
- Defined:
  - Register 0 reads ID_VAL and is read-only.
  - A write to index 0 with be!=0 sets pwr_error=1, leaves the value unchanged, and produces no pulse.
  - A write to index 0 with be=0 completes with no error.
  - cfg_regs[63:0] = ID_VAL.
- Undefined: register 0 is an ordinary R/W register.

Test Plan:
- Reset, then read add=3 → ack rises on the 4th edge after req; r_data=RESET_VAL, error=0; ack falls 3 edges after req drops.
- Write add=2, be=8'h0F, data=64'h1111_2222_3333_4444 onto RESET_VAL=0, then read add=2 → r_data=64'h0000_0000_3333_4444; cfg_wr_pulse[2] high for exactly 1 cycle.
- Write add=NUM_REGS (16), be=8'hFF → error=1, no cfg_wr_pulse, bank unchanged; subsequent read add=16 → error=1, r_data=0.
- Write add=5, be=8'h00 → error=0, reg 5 unchanged, no pulse.
- Assert HRESETn low while in ACK after a write to add=1 → ack=0 immediately; after release, reg 1 reads RESET_VAL.
- With CVP_PWR_TGT_RO_ID_EN defined: read add=0 → ID_VAL; write add=0, be=8'hFF → error=1 and a re-read still returns ID_VAL.
